pc_ir: RTL and testbench

- Fetch-side datapath stage of mycpu, directly upstream of the control unit.
- Holds the program counter (PC) and instruction register (IR), and drives the memory address mux (PC vs. register A bus).
- Presents the latched instruction to the control unit and applies the control unit's PC-select, IL and MM decisions.
- Optionally counts retired instructions for debug.

---
 rtl/mycpu_pkg.sv | 21 ++
 rtl/pc_next.sv | 31 +++
 rtl/pc_ir.sv | 64 ++++++
 tb/tb_pc_ir.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared mycpu types: PC-select encoding and the relative-branch offset field.
package mycpu_pkg;

   typedef enum logic [1:0] {
      PS_HOLD   = 2'b00,
      PS_INC    = 2'b01,
      PS_BRANCH = 2'b10,
      PS_JUMP   = 2'b11
   } pc_sel_t;

   localparam int BR_OFF_W = 6;

   // Offset is {IR[8:6], IR[2:0]}, sign-extended to a full 16-bit word;
   // callers truncate to their address width (PC math is modulo 2^AW).
   function automatic logic [15:0] br_offset(input logic [15:0] ins);
      logic [BR_OFF_W-1:0] off;
      off = {ins[8:6], ins[2:0]};
      return {{(16-BR_OFF_W){off[BR_OFF_W-1]}}, off};
   endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: hold, increment, IR-relative branch, or jump to A bus.
module pc_next
   import mycpu_pkg::*;
#(
   parameter int DW = 16,
   parameter int AW = 16
) (
   input  logic [AW-1:0] pc,
   input  pc_sel_t       ps,
   input  logic [DW-1:0] ir,
   input  logic [DW-1:0] a,
   output logic [AW-1:0] pc_nxt
);

   logic [DW-1:0] off_full;
   logic [AW-1:0] off;

   assign off_full = br_offset(ir);
   assign off      = off_full[AW-1:0];

   always_comb begin
      pc_nxt = pc;
      case (ps)
         PS_HOLD:   pc_nxt = pc;
         PS_INC:    pc_nxt = pc + AW'(1);
         PS_BRANCH: pc_nxt = pc + off;
         default:   pc_nxt = a[AW-1:0];
      endcase
   end

endmodule

// File: rtl/pc_ir.sv
// mycpu fetch stage: PC and IR registers plus memory address mux.
// Optional retired-instruction counter enabled by MYCPU_ICOUNT_EN.
module pc_ir
   import mycpu_pkg::*;
#(
   parameter int            DW       = 16,
   parameter int            AW       = 16,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    ps_in,
   input  logic          il_in,
   input  logic          mm_in,
   input  logic [DW-1:0] a_in,
   input  logic [DW-1:0] mem_data_in,
   output logic [DW-1:0] ins_out,
   output logic [AW-1:0] pc_out,
   output logic [AW-1:0] addr_out,
   output logic [15:0]   icount_out
);

   logic [AW-1:0] pc;
   logic [AW-1:0] pc_nxt;
   logic [DW-1:0] ir;

   // Branch offset comes from the registered IR, so a simultaneous load
   // still branches relative to the instruction being executed.
   pc_next #(.DW(DW), .AW(AW)) u_pc_next (
      .pc     (pc),
      .ps     (pc_sel_t'(ps_in)),
      .ir     (ir),
      .a      (a_in),
      .pc_nxt (pc_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
         ir <= '0;
      end else begin
         pc <= pc_nxt;
         if (il_in) ir <= mem_data_in;
      end
   end

   assign ins_out  = ir;
   assign pc_out   = pc;
   assign addr_out = mm_in ? pc : a_in[AW-1:0];

`ifdef MYCPU_ICOUNT_EN
   logic [15:0] icount;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        icount <= '0;
      else if (il_in) icount <= icount + 16'd1;
   end

   assign icount_out = icount;
`else
   assign icount_out = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_ir.sv
// Directed self-checking bench for pc_ir (AW=16 main instance, AW=12 for truncation).
module tb_pc_ir;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  ps_in;
   logic        il_in;
   logic        mm_in;
   logic [15:0] a_in;
   logic [15:0] mem_data_in;

   logic [15:0] ins_out,  ins12;
   logic [15:0] pc_out;
   logic [11:0] pc12;
   logic [15:0] addr_out;
   logic [11:0] addr12;
   logic [15:0] icount_out, icount12;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pc_ir #(.DW(16), .AW(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst), .ps_in(ps_in), .il_in(il_in), .mm_in(mm_in),
      .a_in(a_in), .mem_data_in(mem_data_in), .ins_out(ins_out),
      .pc_out(pc_out), .addr_out(addr_out), .icount_out(icount_out)
   );

   pc_ir #(.DW(16), .AW(12), .RESET_PC(12'h000)) dut12 (
      .clk(clk), .rst(rst), .ps_in(ps_in), .il_in(il_in), .mm_in(mm_in),
      .a_in(a_in), .mem_data_in(mem_data_in), .ins_out(ins12),
      .pc_out(pc12), .addr_out(addr12), .icount_out(icount12)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] ps, input logic il, input logic mm,
                        input logic [15:0] a, input logic [15:0] md);
      ps_in = ps; il_in = il; mm_in = mm; a_in = a; mem_data_in = md;
   endtask

   initial begin
      rst = 1'b1;
      drive(2'b00, 1'b0, 1'b1, 16'h0000, 16'h0000);
      #12;
      chk("rst_pc",  pc_out,     16'h0000);
      chk("rst_ir",  ins_out,    16'h0000);
      chk("rst_ic",  icount_out, 16'h0000);
      chk("rst_pc12", pc12,      12'h000);

      rst = 1'b0;
      drive(2'b01, 1'b0, 1'b1, 16'h0000, 16'h0000);
      step();
      chk("inc_after_rst", pc_out, 16'h0001);

      // Mid-run asynchronous reset
      drive(2'b11, 1'b1, 1'b1, 16'h0042, 16'hBEEF);
      step();
      chk("jmp42_pc", pc_out,  16'h0042);
      chk("jmp42_ir", ins_out, 16'hBEEF);
      drive(2'b00, 1'b0, 1'b1, 16'h0000, 16'h0000);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_pc", pc_out,  16'h0000);
      chk("async_rst_ir", ins_out, 16'h0000);
      chk("async_rst_ic", icount_out, 16'h0000);
      #2 rst = 1'b0;
      drive(2'b01, 1'b0, 1'b1, 16'h0000, 16'h0000);
      step();
      chk("rel_inc_pc", pc_out, 16'h0001);

      // Fetch
      drive(2'b11, 1'b0, 1'b1, 16'h0005, 16'h0000);
      step();
      drive(2'b00, 1'b1, 1'b1, 16'h7777, 16'h1234);
      #1;
      chk("fetch_addr", addr_out, 16'h0005);
      step();
      chk("fetch_ir", ins_out, 16'h1234);
      chk("fetch_pc", pc_out,  16'h0005);
      drive(2'b01, 1'b0, 1'b1, 16'h0000, 16'h0000);
      step();
      chk("fetch_inc", pc_out, 16'h0006);

      // Branch -2 (IR 0xA1C6)
      drive(2'b11, 1'b1, 1'b1, 16'h0010, 16'hA1C6);
      step();
      drive(2'b10, 1'b0, 1'b1, 16'h0000, 16'h0000);
      step();
      chk("br_m2", pc_out, 16'h000E);

      // Branch +31 from FFF0 wraps
      drive(2'b11, 1'b1, 1'b1, 16'hFFF0, 16'h00C7);
      step();
      drive(2'b10, 1'b0, 1'b1, 16'h0000, 16'h0000);
      step();
      chk("br_p31_wrap", pc_out, 16'h000F);

      // Increment wrap FFFF -> 0
      drive(2'b11, 1'b1, 1'b1, 16'hFFFF, 16'h01C7);
      step();
      drive(2'b01, 1'b0, 1'b1, 16'h0000, 16'h0000);
      step();
      chk("inc_wrap", pc_out, 16'h0000);
      // Branch -1 from 0 (IR still 0x01C7) wraps to FFFF
      drive(2'b10, 1'b0, 1'b1, 16'h0000, 16'h0000);
      step();
      chk("br_m1_wrap", pc_out, 16'hFFFF);

      // Jump with AW=12 truncation and A-bus address mux
      drive(2'b11, 1'b0, 1'b0, 16'hABCD, 16'h0000);
      step();
      chk("jmp_pc12",  pc12,     12'hBCD);
      chk("jmp_pc16",  pc_out,   16'hABCD);
      chk("mux_a12",   addr12,   12'hBCD);
      drive(2'b00, 1'b0, 1'b0, 16'h1357, 16'h0000);
      #1;
      chk("mux_a12_comb", addr12,   12'h357);
      chk("mux_a16_comb", addr_out, 16'h1357);
      mm_in = 1'b1;
      #1;
      chk("mux_pc12", addr12, 12'hBCD);

      // Simultaneous IR load and branch: old offset +3 applies
      drive(2'b11, 1'b1, 1'b1, 16'h0014, 16'h0003);
      step();
      drive(2'b10, 1'b1, 1'b1, 16'h0000, 16'h01C0);
      step();
      chk("sim_pc", pc_out,  16'h0017);
      chk("sim_ir", ins_out, 16'h01C0);

      // Instruction counter
      drive(2'b00, 1'b0, 1'b1, 16'h0000, 16'h0000);
      rst = 1'b1;
      #2 rst = 1'b0;
      il_in = 1'b1;
      for (int i = 0; i < 5; i++) step();
      il_in = 1'b0;
      step();
`ifdef MYCPU_ICOUNT_EN
      chk("icount5", icount_out, 16'd5);
      il_in = 1'b1;
      for (int i = 0; i < 65530; i++) step();
      il_in = 1'b0;
      step();
      chk("icount_ffff", icount_out, 16'hFFFF);
      il_in = 1'b1;
      step();
      il_in = 1'b0;
      chk("icount_wrap", icount_out, 16'h0000);
`else
      chk("icount_off", icount_out, 16'h0000);
      chk("icount_off12", icount12, 16'h0000);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
